// File: rtl/dm_pkg.sv
// Shared types and the byte-lane merge helper for the data-memory controller.
package dm_pkg;

    localparam int unsigned DM_WORD_W = 32;
    localparam int unsigned DM_LANES  = 4;

    typedef logic [DM_WORD_W-1:0] dm_word_t;
    typedef logic [DM_LANES-1:0]  dm_lane_en_t;

    // Replace each byte of old_word whose lane enable is set with the byte from new_word.
    function automatic dm_word_t lane_merge(dm_word_t old_word, dm_word_t new_word,
                                            dm_lane_en_t wen);
        dm_word_t res;
        res = old_word;
        for (int i = 0; i < int'(DM_LANES); i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_rd_pipe.sv
// Read-response pipeline: RD_LAT stages of {valid, word index, data}.
// With DM_FWD_EN defined, writes accepted while a read is in flight merge into that read's data.
module dm_rd_pipe
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_idx,
    input  dm_word_t          in_data,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_idx,
    input  dm_word_t          wr_data,
    input  dm_lane_en_t       wr_wen,
    output logic              out_valid,
    output dm_word_t          out_data
);

    logic              valid_q [RD_LAT];
    logic [ADDR_W-1:0] idx_q   [RD_LAT];
    dm_word_t          data_q  [RD_LAT];

    logic              src_valid [RD_LAT];
    logic [ADDR_W-1:0] src_idx   [RD_LAT];
    dm_word_t          src_data  [RD_LAT];
    dm_word_t          stage_in  [RD_LAT];

    // Values entering each stage this edge, with in-flight write forwarding when enabled.
    always_comb begin
        src_valid[0] = in_valid;
        src_idx[0]   = in_idx;
        src_data[0]  = in_data;
        for (int s = 1; s < int'(RD_LAT); s++) begin
            src_valid[s] = valid_q[s-1];
            src_idx[s]   = idx_q[s-1];
            src_data[s]  = data_q[s-1];
        end
        for (int s = 0; s < int'(RD_LAT); s++) begin
            stage_in[s] = src_data[s];
`ifdef DM_FWD_EN
            if (wr_acc && src_valid[s] && (src_idx[s] == wr_idx)) begin
                stage_in[s] = lane_merge(src_data[s], wr_data, wr_wen);
            end
`endif
        end
    end

`ifndef DM_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{wr_acc, wr_idx, wr_data, wr_wen};
`endif

    // Last stage index is never consumed; it only exists to keep stages uniform.
    logic [ADDR_W-1:0] unused_last_idx;
    assign unused_last_idx = idx_q[RD_LAT-1];

    // Shift stages; the output stage only reloads data on a valid response so dm_rdata holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(RD_LAT); s++) begin
                valid_q[s] <= 1'b0;
                idx_q[s]   <= '0;
                data_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < int'(RD_LAT); s++) begin
                valid_q[s] <= src_valid[s];
                idx_q[s]   <= src_idx[s];
                if ((s != int'(RD_LAT) - 1) || src_valid[s]) begin
                    data_q[s] <= stage_in[s];
                end
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-memory responder: word RAM with byte-lane writes, fixed-latency read pipeline,
// a latency-1 debug read port and a saturating write counter.
// Optional feature macro: DM_FWD_EN (forward in-flight writes into pending read responses).
module data_ram_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_en,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_rvalid,
    input  logic [31:0] test_addr,
    output logic [31:0] test_data,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_rd_lat
        $error("data_ram_ctrl: RD_LAT must be in 1..3");
    end

    dm_word_t mem [DEPTH];

    logic [ADDR_W-1:0] dm_idx;
    logic [ADDR_W-1:0] test_idx;
    logic              wr_acc;
    dm_word_t          rd_word;

    assign dm_idx   = dm_addr[ADDR_W+1:2];
    assign test_idx = test_addr[ADDR_W+1:2];
    assign wr_acc   = !rst && dm_en && (|dm_wen);
    // Combinational array read sampled at the edge gives read-first behaviour.
    assign rd_word  = mem[dm_idx];

    // Upper address bits wrap and the byte offset is the requester's concern.
    logic unused_addr;
    assign unused_addr = ^{dm_addr[31:ADDR_W+2], dm_addr[1:0],
                           test_addr[31:ADDR_W+2], test_addr[1:0]};

    // Byte-lane write port; the array is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[dm_idx] <= lane_merge(mem[dm_idx], dm_wdata, dm_wen);
        end
    end

    // Debug read port, latency 1, independent of the functional port.
    always_ff @(posedge clk) begin
        if (rst) begin
            test_data <= '0;
        end else begin
            test_data <= mem[test_idx];
        end
    end

    // Accepted-write counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (wr_acc && (wr_cnt != 32'hFFFF_FFFF)) begin
            wr_cnt <= wr_cnt + 32'd1;
        end
    end

    dm_rd_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (dm_en),
        .in_idx    (dm_idx),
        .in_data   (rd_word),
        .wr_acc    (wr_acc),
        .wr_idx    (dm_idx),
        .wr_data   (dm_wdata),
        .wr_wen    (dm_wen),
        .out_valid (dm_rvalid),
        .out_data  (dm_rdata)
    );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honours DM_FWD_EN when defined.
module tb_data_ram_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dm_en = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [3:0]  dm_wen = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] test_addr = '0;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic [31:0] test_data;
    logic [31:0] wr_cnt;

    always #5 clk = ~clk;

    data_ram_ctrl #(
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dm_en     (dm_en),
        .dm_addr   (dm_addr),
        .dm_wen    (dm_wen),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_rvalid (dm_rvalid),
        .test_addr (test_addr),
        .test_data (test_data),
        .wr_cnt    (wr_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: array contents, known-ness per word, queue of pending responses.
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
        int unsigned idx;
    } rd_t;

    logic [31:0] mem_m   [DEPTH];
    bit          known_m [DEPTH];
    rd_t         pend[$];
    int          edge_n = 0;
    logic        exp_rvalid = 1'b0;
    logic [31:0] exp_rdata  = '0;
    logic [31:0] exp_test   = '0;
    logic [31:0] exp_cnt    = '0;
    bit          rdata_known = 1'b1;
    bit          test_known  = 1'b1;

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w,
                                          logic [3:0] w);
        logic [31:0] mask;
        mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_edge();
        int unsigned wi;
        int unsigned ti;
        edge_n++;
        if (rst) begin
            pend.delete();
            exp_rvalid  = 1'b0;
            exp_rdata   = '0;
            rdata_known = 1'b1;
            exp_test    = '0;
            test_known  = 1'b1;
            exp_cnt     = '0;
            return;
        end
        ti = (test_addr >> 2) % DEPTH;
        wi = (dm_addr >> 2) % DEPTH;
        exp_test   = mem_m[ti];
        test_known = known_m[ti];
        if (dm_en) begin
            pend.push_back('{edge_n + int'(RD_LAT) - 1, mem_m[wi], known_m[wi], wi});
        end
        if (dm_en && (dm_wen != 4'h0)) begin
`ifdef DM_FWD_EN
            foreach (pend[i]) begin
                if (pend[i].idx == wi) begin
                    pend[i].data  = merge(pend[i].data, dm_wdata, dm_wen);
                    pend[i].known = pend[i].known || (dm_wen == 4'hF);
                end
            end
`endif
            mem_m[wi]   = merge(mem_m[wi], dm_wdata, dm_wen);
            known_m[wi] = known_m[wi] || (dm_wen == 4'hF);
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        end
        if ((pend.size() > 0) && (pend[0].due == edge_n)) begin
            exp_rvalid  = 1'b1;
            exp_rdata   = pend[0].data;
            rdata_known = pend[0].known;
            void'(pend.pop_front());
        end else begin
            exp_rvalid = 1'b0;
        end
    endtask

    task automatic compare();
        check_eq("rvalid", {31'b0, dm_rvalid}, {31'b0, exp_rvalid});
        if (rdata_known) check_eq("rdata", dm_rdata, exp_rdata);
        if (test_known) check_eq("test_data", test_data, exp_test);
        check_eq("wr_cnt", wr_cnt, exp_cnt);
    endtask

    // One clock: apply inputs, let the edge happen, update the model, check #1 later.
    task automatic cycle(input logic r, input logic e, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d, input logic [31:0] ta);
        rst       = r;
        dm_en     = e;
        dm_addr   = a;
        dm_wen    = w;
        dm_wdata  = d;
        test_addr = ta;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h100);
    endtask

    initial begin
        // Reset for two cycles.
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 32'h100, 4'hF, 32'h1234_5678, 32'h0);
        check_eq("rst_rvalid", {31'b0, dm_rvalid}, 32'h0);
        check_eq("rst_rdata", dm_rdata, 32'h0);
        check_eq("rst_test", test_data, 32'h0);
        check_eq("rst_wrcnt", wr_cnt, 32'h0);

        // Full-word write then read.
        cycle(1'b0, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h100);
        cycle(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 32'h100);
        repeat (RD_LAT - 1) idle();
        check_eq("t2_rvalid", {31'b0, dm_rvalid}, 32'h1);
        check_eq("t2_rdata", dm_rdata, 32'hDEAD_BEEF);

        // Single-lane write.
        cycle(1'b0, 1'b1, 32'h100, 4'b0010, 32'h0000_AA00, 32'h100);
        cycle(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 32'h100);
        repeat (RD_LAT - 1) idle();
        check_eq("t3_rdata", dm_rdata, 32'hDEAD_AAEF);
        check_eq("t3_wrcnt", wr_cnt, 32'd2);
        idle();
        check_eq("t3_hold", dm_rdata, 32'hDEAD_AAEF);
        check_eq("t3_test", test_data, 32'hDEAD_AAEF);

        // Same-cycle read and write of one word.
        cycle(1'b0, 1'b1, 32'h104, 4'hF, 32'h1111_1111, 32'h0);
        cycle(1'b0, 1'b1, 32'h104, 4'hF, 32'h2222_2222, 32'h104);
        repeat (RD_LAT - 1) idle();
`ifdef DM_FWD_EN
        check_eq("t4_rdw", dm_rdata, 32'h2222_2222);
`else
        check_eq("t4_rdw", dm_rdata, 32'h1111_1111);
`endif
        cycle(1'b0, 1'b1, 32'h104, 4'h0, 32'h0, 32'h0);
        repeat (RD_LAT - 1) idle();
        check_eq("t4_next", dm_rdata, 32'h2222_2222);

        // Write one cycle after a read to the same word (RD_LAT = 2).
        cycle(1'b0, 1'b1, 32'h108, 4'hF, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 32'h108, 4'h0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 32'h108, 4'hF, 32'h5A5A_5A5A, 32'h108);
`ifdef DM_FWD_EN
        check_eq("t5_fwd", dm_rdata, 32'h5A5A_5A5A);
`else
        check_eq("t5_fwd", dm_rdata, 32'h0000_0000);
`endif
        idle();

        // Reset with reads in flight, then address aliasing.
        cycle(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 32'h104, 4'h0, 32'h0, 32'h0);
        idle();
        check_eq("t6_flush0", {31'b0, dm_rvalid}, 32'h0);
        idle();
        check_eq("t6_flush1", {31'b0, dm_rvalid}, 32'h0);
        check_eq("t6_wrcnt", wr_cnt, 32'h0);
        cycle(1'b0, 1'b1, 32'h400, 4'hF, 32'hCAFE_F00D, 32'h0);
        cycle(1'b0, 1'b1, 32'h000, 4'h0, 32'h0, 32'h400);
        check_eq("t6_alias_test", test_data, 32'hCAFE_F00D);
        repeat (RD_LAT - 1) idle();
        check_eq("t6_alias", dm_rdata, 32'hCAFE_F00D);

        // Fill every word so later random reads have known data.
        for (int i = 0; i < int'(DEPTH); i++) begin
            cycle(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, $urandom);
        end

        // Randomized traffic concentrated on a few words to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), a,
                  4'($urandom), $urandom,
                  ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
